// File: rtl/regfile_wb_scoreboard_if.sv
// Decode/write-back side bundle of the register file with its scoreboard.
// The master drives the read indices, issue and write-back requests.
// The slave (the register file) returns read data, stall and the error flag.
interface regfile_wb_scoreboard_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   logic [ADDR_W-1:0] rd_reg1;
   logic [ADDR_W-1:0] rd_reg2;
   logic [DATA_W-1:0] rd_data1;
   logic [DATA_W-1:0] rd_data2;
   logic              src1_vld;
   logic              src2_vld;
   logic              iss_en;
   logic [ADDR_W-1:0] iss_reg;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_reg;
   logic [DATA_W-1:0] wr_data;
   logic              stall;
   logic              err;

   modport master (
      output rd_reg1, rd_reg2, src1_vld, src2_vld,
      output iss_en, iss_reg, wr_en, wr_reg, wr_data,
      input  rd_data1, rd_data2, stall, err
   );

   modport slave (
      input  rd_reg1, rd_reg2, src1_vld, src2_vld,
      input  iss_en, iss_reg, wr_en, wr_reg, wr_data,
      output rd_data1, rd_data2, stall, err
   );
endinterface

// File: rtl/regfile_wb_scoreboard.sv
// Register file fed by write-back, read by decode, with same-cycle
// write-to-read bypass and a per-register outstanding-write counter that
// stalls decode while a source operand still has an in-flight producer.
module regfile_wb_scoreboard #(
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 3,
   parameter int CNT_W    = 2
) (
   input logic clk,
   input logic rst_n,
   regfile_wb_scoreboard_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [DATA_W-1:0]   regs    [NUM_REGS];
   logic [CNT_W-1:0]    cnt     [NUM_REGS];
   logic [CNT_W-1:0]    cnt_nxt [NUM_REGS];
   logic [NUM_REGS-1:0] inc_vec;
   logic [NUM_REGS-1:0] dec_vec;
   logic                err_q;
   logic                err_set;
   logic                hazard1;
   logic                hazard2;
   logic                dst_full;
   logic                stall_c;
   logic                iss_ok;

   // Read ports: write-back data wins over storage for a matching index.
   always_comb begin
      bus.rd_data1 = regs[bus.rd_reg1];
      bus.rd_data2 = regs[bus.rd_reg2];
      if (bus.wr_en && bus.wr_reg == bus.rd_reg1) bus.rd_data1 = bus.wr_data;
      if (bus.wr_en && bus.wr_reg == bus.rd_reg2) bus.rd_data2 = bus.wr_data;
   end

   // Hazard detection; a sole producer retiring this cycle is covered by the bypass.
   always_comb begin
      hazard1  = bus.src1_vld && (cnt[bus.rd_reg1] != CNT_ZERO) &&
                 !(bus.wr_en && bus.wr_reg == bus.rd_reg1 && cnt[bus.rd_reg1] == CNT_ONE);
      hazard2  = bus.src2_vld && (cnt[bus.rd_reg2] != CNT_ZERO) &&
                 !(bus.wr_en && bus.wr_reg == bus.rd_reg2 && cnt[bus.rd_reg2] == CNT_ONE);
      dst_full = bus.iss_en && (cnt[bus.iss_reg] == CNT_MAX);
      stall_c  = hazard1 | hazard2 | dst_full;
      iss_ok   = bus.iss_en && !stall_c;
   end

   assign bus.stall = stall_c;
   assign bus.err   = err_q;

   // Per-register increment/decrement requests.
   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         inc_vec[r] = iss_ok    && (bus.iss_reg == ADDR_W'(r));
         dec_vec[r] = bus.wr_en && (bus.wr_reg  == ADDR_W'(r));
      end
   end

   // Next counter values; overflow and underflow hold the counter and flag an error.
   always_comb begin
      err_set = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_nxt[r] = cnt[r];
         if (inc_vec[r] && !dec_vec[r]) begin
            if (cnt[r] == CNT_MAX) err_set = 1'b1;
            else                   cnt_nxt[r] = cnt[r] + CNT_ONE;
         end else if (dec_vec[r] && !inc_vec[r]) begin
            if (cnt[r] == CNT_ZERO) err_set = 1'b1;
            else                    cnt_nxt[r] = cnt[r] - CNT_ONE;
         end
      end
   end

   // Storage, scoreboard counters and sticky error flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs[r] <= '0;
            cnt[r]  <= '0;
         end
         err_q <= 1'b0;
      end else begin
         if (bus.wr_en) regs[bus.wr_reg] <= bus.wr_data;
         for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_nxt[r];
         if (err_set) err_q <= 1'b1;
      end
   end
endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Directed bench: stimulus pushes expected port values into a queue and a
// negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_wb_scoreboard;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   typedef struct {
      string       name;
      logic        cd1;
      logic [15:0] e1;
      logic        cd2;
      logic [15:0] e2;
      logic        es;
      logic        ee;
   } exp_t;

   exp_t exp_q[$];

   regfile_wb_scoreboard_if #(.DATA_W(16), .ADDR_W(3)) bus ();

   regfile_wb_scoreboard #(
      .DATA_W(16), .NUM_REGS(8), .ADDR_W(3), .CNT_W(2)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
      end
   endtask

   // Monitor: one expectation per cycle, sampled mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         if (e.cd1) cmp(e.name, "rd_data1", bus.rd_data1, e.e1);
         if (e.cd2) cmp(e.name, "rd_data2", bus.rd_data2, e.e2);
         cmp(e.name, "stall", {15'd0, bus.stall}, {15'd0, e.es});
         cmp(e.name, "err",   {15'd0, bus.err},   {15'd0, e.ee});
      end
   end

   task automatic drive(
      input string nm,
      input logic [2:0] r1, input logic [2:0] r2, input logic s1, input logic s2,
      input logic ie, input logic [2:0] ir,
      input logic we, input logic [2:0] wr, input logic [15:0] wd,
      input logic cd1, input logic [15:0] e1, input logic cd2, input logic [15:0] e2,
      input logic es, input logic ee);
      exp_t e;
      bus.rd_reg1  = r1;
      bus.rd_reg2  = r2;
      bus.src1_vld = s1;
      bus.src2_vld = s2;
      bus.iss_en   = ie;
      bus.iss_reg  = ir;
      bus.wr_en    = we;
      bus.wr_reg   = wr;
      bus.wr_data  = wd;
      e.name = nm; e.cd1 = cd1; e.e1 = e1; e.cd2 = cd2; e.e2 = e2; e.es = es; e.ee = ee;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus.rd_reg1 = 3'd0; bus.rd_reg2 = 3'd0; bus.src1_vld = 1'b0; bus.src2_vld = 1'b0;
      bus.iss_en = 1'b0; bus.iss_reg = 3'd0; bus.wr_en = 1'b0; bus.wr_reg = 3'd0;
      bus.wr_data = 16'h0;
      // name          r1 r2 s1 s2  ie ir  we wr wd        cd1 e1       cd2 e2       es ee
      drive("in_reset",  3, 5, 1, 1,  0, 0,  0, 0, 16'h0,    1, 16'h0,    1, 16'h0,    0, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      drive("rst_read",  3, 5, 1, 1,  0, 0,  0, 0, 16'h0,    1, 16'h0,    1, 16'h0,    0, 0);
      drive("iss_r2",    0, 0, 0, 0,  1, 2,  0, 0, 16'h0,    0, 16'h0,    0, 16'h0,    0, 0);
      drive("byp_wr",    2, 5, 1, 1,  0, 0,  1, 2, 16'hBEEF, 1, 16'hBEEF, 1, 16'h0,    0, 0);
      drive("stor_rd",   2, 5, 1, 1,  0, 0,  0, 0, 16'h0,    1, 16'hBEEF, 1, 16'h0,    0, 0);
      drive("iss_r4",    0, 0, 0, 0,  1, 4,  0, 0, 16'h0,    0, 16'h0,    0, 16'h0,    0, 0);
      drive("raw_stall", 4, 0, 1, 0,  0, 0,  0, 0, 16'h0,    0, 16'h0,    0, 16'h0,    1, 0);
      drive("raw_retire",4, 0, 1, 0,  0, 0,  1, 4, 16'h1234, 1, 16'h1234, 0, 16'h0,    0, 0);
      drive("raw_after", 4, 0, 1, 0,  0, 0,  0, 0, 16'h0,    1, 16'h1234, 0, 16'h0,    0, 0);
      drive("iss_r6a",   0, 0, 0, 0,  1, 6,  0, 0, 16'h0,    0, 16'h0,    0, 16'h0,    0, 0);
      drive("iss_r6b",   0, 0, 0, 0,  1, 6,  0, 0, 16'h0,    0, 16'h0,    0, 16'h0,    0, 0);
      drive("dbl_wb1",   6, 0, 1, 0,  0, 0,  1, 6, 16'h0606, 1, 16'h0606, 0, 16'h0,    1, 0);
      drive("dbl_wb2",   6, 0, 1, 0,  0, 0,  1, 6, 16'h0660, 1, 16'h0660, 0, 16'h0,    0, 0);
      drive("dbl_after", 6, 0, 1, 0,  0, 0,  0, 0, 16'h0,    1, 16'h0660, 0, 16'h0,    0, 0);
      drive("iss_r1",    0, 0, 0, 0,  1, 1,  0, 0, 16'h0,    0, 16'h0,    0, 16'h0,    0, 0);
      drive("iss_ret_r1",1, 0, 0, 0,  1, 1,  1, 1, 16'h0011, 1, 16'h0011, 0, 16'h0,    0, 0);
      drive("r1_pending",1, 0, 1, 0,  0, 0,  0, 0, 16'h0,    1, 16'h0011, 0, 16'h0,    1, 0);
      drive("r1_retire", 1, 0, 1, 0,  0, 0,  1, 1, 16'h0022, 1, 16'h0022, 0, 16'h0,    0, 0);
      drive("iss_r7a",   0, 0, 0, 0,  1, 7,  0, 0, 16'h0,    0, 16'h0,    0, 16'h0,    0, 0);
      drive("iss_r7b",   0, 0, 0, 0,  1, 7,  0, 0, 16'h0,    0, 16'h0,    0, 16'h0,    0, 0);
      drive("iss_r7c",   0, 0, 0, 0,  1, 7,  0, 0, 16'h0,    0, 16'h0,    0, 16'h0,    0, 0);
      drive("r7_full",   0, 0, 0, 0,  1, 7,  0, 0, 16'h0,    0, 16'h0,    0, 16'h0,    1, 0);
      drive("r7_hold",   0, 0, 0, 0,  1, 7,  0, 0, 16'h0,    0, 16'h0,    0, 16'h0,    1, 0);
      drive("r7_src2",   0, 7, 0, 1,  0, 0,  0, 0, 16'h0,    0, 16'h0,    0, 16'h0,    1, 0);
      drive("undf_wr",   0, 0, 0, 0,  0, 0,  1, 0, 16'h00AA, 0, 16'h0,    1, 16'h00AA, 0, 0);
      drive("undf_err",  0, 0, 0, 0,  0, 0,  0, 0, 16'h0,    0, 16'h0,    1, 16'h00AA, 0, 1);
      drive("err_sticky",0, 0, 0, 0,  0, 0,  0, 0, 16'h0,    0, 16'h0,    1, 16'h00AA, 0, 1);
      rst_n = 1'b0;
      drive("async_rst", 7, 0, 1, 0,  0, 0,  0, 0, 16'h0,    0, 16'h0,    1, 16'h0,    0, 0);
      rst_n = 1'b1;
      drive("post_rst",  7, 2, 1, 1,  0, 0,  0, 0, 16'h0,    0, 16'h0,    1, 16'h0,    0, 0);
      drive("flush_wr",  5, 0, 1, 0,  0, 0,  1, 5, 16'h5555, 1, 16'h5555, 0, 16'h0,    0, 0);
      drive("flush_err", 5, 0, 1, 0,  0, 0,  0, 0, 16'h0,    1, 16'h5555, 0, 16'h0,    0, 1);

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
